ram_stream_master: RTL and testbench

- Initiator for the synchronous byte RAM. It drives the RAM's address, active-low chip select, active-low write enable and write data.
- Moves a contiguous block of bytes between the RAM and a valid/ready byte stream.
  - Write mode: stream in, RAM written.
  - Read mode: RAM read, stream out.
- Sits between the host-side transfer logic (memory load/dump) and the RAM instance. It is the only driver of the RAM's control pins while busy.

---
 rtl/ram_stream_master_pkg.sv | 21 ++
 rtl/ram_stream_master.sv | 198 +++++++++++++++++++
 tb/tb_ram_stream_master.sv | 303 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ram_stream_master_pkg.sv
// Shared types and constants for the RAM stream master: FSM states, default widths
// and the active-low RAM pin encodings.
package ram_stream_master_pkg;

    localparam int unsigned DEF_DATA_WIDTH = 8;
    localparam int unsigned DEF_ADDR_WIDTH = 16;

    localparam logic SEL_ACTIVE = 1'b0;
    localparam logic SEL_IDLE   = 1'b1;
    localparam logic WE_WRITE   = 1'b0;
    localparam logic WE_READ    = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        WR,
        RD_ISSUE,
        RD_CAPTURE,
        RD_HOLD
    } state_e;

endpackage

// File: rtl/ram_stream_master.sv
// Moves a contiguous byte block between the synchronous RAM and a valid/ready stream.
// All RAM pins and handshake outputs come straight from registers.
module ram_stream_master
    import ram_stream_master_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_start,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [ADDR_WIDTH:0]   cmd_len,
    input  logic                  abort,
    output logic                  busy,
    output logic                  done,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_wdata,
    output logic                  ram_cs_n,
    output logic                  ram_we_n,
    input  logic [DATA_WIDTH-1:0] ram_rdata
);

    localparam int unsigned LEN_W = ADDR_WIDTH + 1;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [LEN_W-1:0]      rem_q, rem_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  in_ready_q, in_ready_d;
    logic                  out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic [ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;
    logic [DATA_WIDTH-1:0] ram_wdata_q, ram_wdata_d;
    logic                  ram_cs_n_q, ram_cs_n_d;
    logic                  ram_we_n_q, ram_we_n_d;

    logic wr_hs;
    logic rd_hs;
    logic finish;

    assign wr_hs = in_valid & in_ready_q;
    assign rd_hs = out_valid_q & out_ready;

    // Next-state logic; the RAM pins default to idle so an access lasts exactly one cycle.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        rem_d       = rem_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        in_ready_d  = 1'b0;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        ram_cs_n_d  = SEL_IDLE;
        ram_we_n_d  = WE_READ;
        finish      = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (cmd_start) begin
                    addr_d = cmd_addr;
                    rem_d  = cmd_len;
                    if (cmd_len == '0) begin
                        done_d = 1'b1;
                    end else begin
                        busy_d = 1'b1;
                        if (cmd_write) begin
                            state_d    = WR;
                            in_ready_d = 1'b1;
                        end else begin
                            state_d = RD_ISSUE;
                        end
                    end
                end
            end

            WR: begin
                if (abort) begin
                    finish = 1'b1;
                end else begin
                    in_ready_d = 1'b1;
                    if (wr_hs) begin
                        ram_cs_n_d  = SEL_ACTIVE;
                        ram_we_n_d  = WE_WRITE;
                        ram_addr_d  = addr_q;
                        ram_wdata_d = in_data;
                        addr_d      = addr_q + ADDR_WIDTH'(1);
                        rem_d       = rem_q - LEN_W'(1);
                        if (rem_q == LEN_W'(1)) begin
                            finish = 1'b1;
                        end
                    end
                end
            end

            RD_ISSUE: begin
                if (abort) begin
                    finish = 1'b1;
                end else begin
                    ram_cs_n_d = SEL_ACTIVE;
                    ram_addr_d = addr_q;
                    state_d    = RD_CAPTURE;
                end
            end

            // The select cycle is on the pins now; ram_rdata is valid at the closing edge.
            RD_CAPTURE: begin
                if (abort) begin
                    finish = 1'b1;
                end else begin
                    out_data_d  = ram_rdata;
                    out_valid_d = 1'b1;
                    addr_d      = addr_q + ADDR_WIDTH'(1);
                    rem_d       = rem_q - LEN_W'(1);
                    state_d     = RD_HOLD;
                end
            end

            RD_HOLD: begin
                if (abort) begin
                    finish = 1'b1;
                end else if (rd_hs) begin
                    out_valid_d = 1'b0;
                    if (rem_q == '0) begin
                        finish = 1'b1;
                    end else begin
                        state_d = RD_ISSUE;
                    end
                end
            end

            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase

        if (finish) begin
            state_d     = IDLE;
            busy_d      = 1'b0;
            done_d      = 1'b1;
            in_ready_d  = 1'b0;
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            rem_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            ram_cs_n_q  <= SEL_IDLE;
            ram_we_n_q  <= WE_READ;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            rem_q       <= rem_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
            ram_cs_n_q  <= ram_cs_n_d;
            ram_we_n_q  <= ram_we_n_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign ram_addr  = ram_addr_q;
    assign ram_wdata = ram_wdata_q;
    assign ram_cs_n  = ram_cs_n_q;
    assign ram_we_n  = ram_we_n_q;

endmodule

// File: tb/tb_ram_stream_master.sv
// Directed bench for ram_stream_master with a behavioural falling-edge byte RAM.
module tb_ram_stream_master;

    localparam int unsigned DW = 8;
    localparam int unsigned AW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cmd_start = 1'b0;
    logic          cmd_write = 1'b0;
    logic [AW-1:0] cmd_addr = '0;
    logic [AW:0]   cmd_len = '0;
    logic          abort = 1'b0;
    logic          busy;
    logic          done;
    logic [DW-1:0] in_data = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic          ram_cs_n;
    logic          ram_we_n;
    wire  [DW-1:0] ram_rdata;

    always #5 clk = ~clk;

    ram_stream_master #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst(rst),
        .cmd_start(cmd_start), .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .abort(abort), .busy(busy), .done(done),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_cs_n(ram_cs_n), .ram_we_n(ram_we_n),
        .ram_rdata(ram_rdata)
    );

    // Behavioural RAM: acts on the falling edge, drives read data until the next falling edge.
    typedef struct { int cyc; logic we_n; logic [AW-1:0] addr; logic [DW-1:0] data; } acc_t;

    logic [DW-1:0] mem [0:65535];
    logic [DW-1:0] rd_buf = '0;
    logic          rd_drive = 1'b0;
    acc_t          log_q[$];
    int            cyc = 0;
    int            done_cnt = 0;

    assign ram_rdata = rd_drive ? rd_buf : 8'hzz;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        rd_drive = 1'b0;
        if (done) done_cnt++;
        if (!ram_cs_n) begin
            log_q.push_back('{cyc, ram_we_n, ram_addr, ram_wdata});
            if (!ram_we_n) mem[ram_addr] = ram_wdata;
            else begin
                rd_buf   = mem[ram_addr];
                rd_drive = 1'b1;
            end
        end
    end

    int pass_cnt = 0;
    int chk_cnt  = 0;
    logic [DW-1:0] rd_got [8];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [AW-1:0] addr, input int len, input logic [DW-1:0] d [4]);
        int i;
        int t;
        logic hs;
        cmd_start = 1'b1; cmd_write = 1'b1; cmd_addr = addr; cmd_len = (AW+1)'(len);
        tick();
        cmd_start = 1'b0;
        if (len == 0) begin
            chk("zl_done", 32'(done), 32'd1);
            chk("zl_busy", 32'(busy), 32'd0);
            tick();
            chk("zl_done_low", 32'(done), 32'd0);
            chk("zl_busy_low", 32'(busy), 32'd0);
            return;
        end
        chk("wr_busy", 32'(busy), 32'd1);
        chk("wr_in_ready", 32'(in_ready), 32'd1);
        i = 0; t = 0;
        while (i < len && t < 100) begin
            in_valid = 1'b1;
            in_data  = d[i];
            hs = in_ready;
            tick();
            if (hs) i++;
            t++;
        end
        in_valid = 1'b0;
        chk("wr_count", 32'(i), 32'(len));
        chk("wr_end_done", 32'(done), 32'd1);
        chk("wr_end_busy", 32'(busy), 32'd0);
        chk("wr_end_in_ready", 32'(in_ready), 32'd0);
        chk("wr_end_last_write", 32'({ram_cs_n, ram_we_n}), 32'd0);
    endtask

    task automatic do_read(input logic [AW-1:0] addr, input int len, input int stall_idx,
                           input int stall_n);
        int n;
        int t;
        int nacc;
        logic [DW-1:0] held;
        logic stable;
        cmd_start = 1'b1; cmd_write = 1'b0; cmd_addr = addr; cmd_len = (AW+1)'(len);
        tick();
        cmd_start = 1'b0;
        out_ready = 1'b1;
        n = 0; t = 0;
        while (n < len && t < 200) begin
            if (out_valid) begin
                if (n == stall_idx) begin
                    out_ready = 1'b0;
                    held   = out_data;
                    nacc   = log_q.size();
                    stable = 1'b1;
                    repeat (stall_n) begin
                        tick();
                        if (!out_valid || out_data !== held) stable = 1'b0;
                    end
                    chk("stall_hold", 32'(stable), 32'd1);
                    chk("stall_no_access", 32'(log_q.size() - nacc), 32'd0);
                    out_ready = 1'b1;
                end
                rd_got[n] = out_data;
                n++;
            end
            tick();
            t++;
        end
        chk("rd_count", 32'(n), 32'(len));
        chk("rd_end_done", 32'(done), 32'd1);
        chk("rd_end_busy", 32'(busy), 32'd0);
        chk("rd_end_out_valid", 32'(out_valid), 32'd0);
    endtask

    typedef struct {
        logic [AW-1:0] addr;
        int            len;
        logic [DW-1:0] d  [4];
        logic [AW-1:0] ea [4];
    } vec_t;

    vec_t vecs [4];

    initial begin
        int base;
        int dc;
        int i;
        int t;
        logic hs;
        logic [DW-1:0] dz [4];

        for (int a = 0; a < 65536; a++) mem[a] = '0;
        dz = '{8'h00, 8'h00, 8'h00, 8'h00};

        vecs[0] = '{16'h0100, 4, '{8'h11, 8'h22, 8'h33, 8'h44},
                    '{16'h0100, 16'h0101, 16'h0102, 16'h0103}};
        vecs[1] = '{16'hFFFE, 4, '{8'hA1, 8'hB2, 8'hC3, 8'hD4},
                    '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001}};
        vecs[2] = '{16'h2000, 1, '{8'h5A, 8'h00, 8'h00, 8'h00},
                    '{16'h2000, 16'h0000, 16'h0000, 16'h0000}};
        vecs[3] = '{16'h0000, 0, '{8'h00, 8'h00, 8'h00, 8'h00},
                    '{16'h0000, 16'h0000, 16'h0000, 16'h0000}};

        // Reset values
        rst = 1'b1;
        tick(); tick();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_ram_addr", 32'(ram_addr), 32'd0);
        chk("rst_ram_wdata", 32'(ram_wdata), 32'd0);
        chk("rst_ram_pins", 32'({ram_cs_n, ram_we_n}), 32'd3);
        rst = 1'b0;
        tick();

        // Table: write each block, check the access trail, then read it back
        for (int v = 0; v < 4; v++) begin
            base = log_q.size();
            dc   = done_cnt;
            do_write(vecs[v].addr, vecs[v].len, vecs[v].d);
            tick(); tick();
            chk("wr_access_count", 32'(log_q.size() - base), 32'(vecs[v].len));
            chk("wr_done_pulses", 32'(done_cnt - dc), 32'd1);
            for (int k = 0; k < vecs[v].len && base + k < log_q.size(); k++) begin
                chk("wr_addr", 32'(log_q[base+k].addr), 32'(vecs[v].ea[k]));
                chk("wr_data", 32'(log_q[base+k].data), 32'(vecs[v].d[k]));
                chk("wr_we_n", 32'(log_q[base+k].we_n), 32'd0);
                chk("wr_back_to_back", 32'(log_q[base+k].cyc - log_q[base].cyc), 32'(k));
            end
            if (vecs[v].len > 0) begin
                do_read(vecs[v].addr, vecs[v].len, -1, 0);
                for (int k = 0; k < vecs[v].len; k++)
                    chk("rd_data", 32'(rd_got[k]), 32'(vecs[v].d[k]));
            end
            tick();
        end

        // Backpressure on the second byte of a three-byte read
        do_read(16'h0100, 3, 1, 5);
        chk("bp_b0", 32'(rd_got[0]), 32'h11);
        chk("bp_b1", 32'(rd_got[1]), 32'h22);
        chk("bp_b2", 32'(rd_got[2]), 32'h33);
        tick();

        // Abort while idle is ignored
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("idle_abort_done", 32'(done), 32'd0);
        chk("idle_abort_busy", 32'(busy), 32'd0);

        // Abort after the second of six write bytes; the third is offered with the abort
        base = log_q.size();
        dc   = done_cnt;
        cmd_start = 1'b1; cmd_write = 1'b1; cmd_addr = 16'h3000; cmd_len = 17'd6;
        tick();
        cmd_start = 1'b0;
        i = 0; t = 0;
        while (i < 2 && t < 50) begin
            in_valid = 1'b1;
            in_data  = 8'hA0 + 8'(i);
            hs = in_ready;
            tick();
            if (hs) i++;
            t++;
        end
        in_data = 8'hA2;
        abort   = 1'b1;
        tick();
        abort    = 1'b0;
        in_valid = 1'b0;
        chk("ab_in_ready", 32'(in_ready), 32'd0);
        chk("ab_done", 32'(done), 32'd1);
        chk("ab_busy", 32'(busy), 32'd0);
        chk("ab_cs_n", 32'(ram_cs_n), 32'd1);
        tick();
        chk("ab_done_low", 32'(done), 32'd0);
        chk("ab_writes", 32'(log_q.size() - base), 32'd2);
        chk("ab_done_pulses", 32'(done_cnt - dc), 32'd1);
        do_read(16'h3000, 3, -1, 0);
        chk("ab_rd0", 32'(rd_got[0]), 32'hA0);
        chk("ab_rd1", 32'(rd_got[1]), 32'hA1);
        chk("ab_rd2_untouched", 32'(rd_got[2]), 32'h00);
        tick();

        // Reset while a read byte is waiting on the stream
        cmd_start = 1'b1; cmd_write = 1'b0; cmd_addr = 16'h0100; cmd_len = 17'd4;
        out_ready = 1'b0;
        tick();
        cmd_start = 1'b0;
        t = 0;
        while (!out_valid && t < 20) begin
            tick();
            t++;
        end
        chk("rr_out_valid_before", 32'(out_valid), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rr_out_valid", 32'(out_valid), 32'd0);
        chk("rr_cs_n", 32'(ram_cs_n), 32'd1);
        chk("rr_busy", 32'(busy), 32'd0);
        tick();
        chk("rr_cs_n_after", 32'(ram_cs_n), 32'd1);
        do_read(16'h0100, 4, -1, 0);
        chk("rr_b0", 32'(rd_got[0]), 32'h11);
        chk("rr_b1", 32'(rd_got[1]), 32'h22);
        chk("rr_b2", 32'(rd_got[2]), 32'h33);
        chk("rr_b3", 32'(rd_got[3]), 32'h44);

        // Zero-length write leaves the RAM alone (dz unused data)
        base = log_q.size();
        do_write(16'h4000, 0, dz);
        tick();
        chk("zl_no_access", 32'(log_q.size() - base), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
